// File: rtl/mouse_pos_ctrl_pkg.sv
// Types and defaults for the cursor-position sequencer.
package mouse_pos_ctrl_pkg;
  import vga_pkg::*;

  localparam int COORD_W   = 12;
  localparam int X_MAX_DEF = H_VISIBLE - 1;
  localparam int Y_MAX_DEF = V_VISIBLE - 1;

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  typedef enum logic {SRC_MOUSE, SRC_WARP} src_t;

  typedef struct packed {
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    src_t               src;
    logic               valid;
  } pos_t;
endpackage

// File: rtl/vga_pkg.sv
// Visible-area geometry of the VGA timing chain, shared by the display-path blocks.
package vga_pkg;
  localparam int H_VISIBLE = 800;
  localparam int V_VISIBLE = 600;
endpackage

// File: rtl/mouse_pos_ctrl_if.sv
// Sample/warp inputs and committed-position outputs of the cursor sequencer.
interface mouse_pos_ctrl_if;
  import mouse_pos_ctrl_pkg::*;

  logic               vblnk;
  logic               enable;
  logic               m_valid;
  logic [COORD_W-1:0] m_xpos;
  logic [COORD_W-1:0] m_ypos;
  logic               w_req;
  logic [COORD_W-1:0] w_xpos;
  logic [COORD_W-1:0] w_ypos;
  logic               w_busy;
  logic               w_ack;
  logic [COORD_W-1:0] xpos;
  logic [COORD_W-1:0] ypos;
  logic               frame_upd;

  modport slave (
    input  vblnk, enable, m_valid, m_xpos, m_ypos, w_req, w_xpos, w_ypos,
    output w_busy, w_ack, xpos, ypos, frame_upd
  );

  modport master (
    output vblnk, enable, m_valid, m_xpos, m_ypos, w_req, w_xpos, w_ypos,
    input  w_busy, w_ack, xpos, ypos, frame_upd
  );
endinterface

// File: rtl/mouse_pos_ctrl_pos_clamp.sv
// Saturates one coordinate to MAX; purely combinational, zero latency, no flow control.
module mouse_pos_ctrl_pos_clamp #(
  parameter int       W   = 12,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat
);
  assign out_dat = (in_dat > MAX) ? MAX : in_dat;
endmodule

// File: rtl/mouse_pos_ctrl.sv
// Holds the latest mouse sample or warp and commits it once per frame at vblank rise.
// Latency: vblnk high at cycle N -> outputs at N+2; inputs are strobes, never stalled.
module mouse_pos_ctrl
  import mouse_pos_ctrl_pkg::*;
#(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int X_INIT = 400,
  parameter int Y_INIT = 300
) (
  input  logic             clk,
  input  logic             rst,
  mouse_pos_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  pos_t               slot_q, slot_d;
  pos_t               slot_base;
  logic               vblnk_q;
  logic               vb_rise;
  logic               mouse_ok;
  logic               cap;
  logic [COORD_W-1:0] raw_x, raw_y, clamp_x, clamp_y;
  logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic               frame_upd_q, frame_upd_d;
  logic               w_ack_q, w_ack_d;
  logic               w_busy_q, w_busy_d;

  // Warp has priority, so the mux picks it whenever it strobes.
  assign raw_x = bus.w_req ? bus.w_xpos : bus.m_xpos;
  assign raw_y = bus.w_req ? bus.w_ypos : bus.m_ypos;

  mouse_pos_ctrl_pos_clamp #(.W(COORD_W), .MAX(COORD_W'(X_MAX))) u_clamp_x (
    .in_dat  (raw_x),
    .out_dat (clamp_x)
  );

  mouse_pos_ctrl_pos_clamp #(.W(COORD_W), .MAX(COORD_W'(Y_MAX))) u_clamp_y (
    .in_dat  (raw_y),
    .out_dat (clamp_y)
  );

  always_comb begin
    vb_rise     = bus.vblnk & ~vblnk_q;
    // The commit cycle empties the slot before any same-cycle capture lands.
    slot_base   = (state_q == COMMIT) ? '0 : slot_q;
    mouse_ok    = bus.m_valid & ~bus.w_req &
                  (~slot_base.valid | (slot_base.src == SRC_MOUSE));
    cap         = bus.w_req | mouse_ok;

    slot_d      = slot_base;
    state_d     = state_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    frame_upd_d = 1'b0;
    w_ack_d     = 1'b0;

    if (cap) begin
      slot_d.px    = clamp_x;
      slot_d.py    = clamp_y;
      slot_d.src   = bus.w_req ? SRC_WARP : SRC_MOUSE;
      slot_d.valid = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cap) state_d = PENDING;
      end
      PENDING: begin
        if (vb_rise && bus.enable) state_d = COMMIT;
      end
      COMMIT: begin
        xpos_d      = slot_q.px;
        ypos_d      = slot_q.py;
        frame_upd_d = 1'b1;
        w_ack_d     = (slot_q.src == SRC_WARP);
        state_d     = cap ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase

    w_busy_d = slot_d.valid & (slot_d.src == SRC_WARP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      vblnk_q     <= 1'b0;
      xpos_q      <= COORD_W'(X_INIT);
      ypos_q      <= COORD_W'(Y_INIT);
      frame_upd_q <= 1'b0;
      w_ack_q     <= 1'b0;
      w_busy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      vblnk_q     <= bus.vblnk;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      frame_upd_q <= frame_upd_d;
      w_ack_q     <= w_ack_d;
      w_busy_q    <= w_busy_d;
    end
  end

  assign bus.xpos      = xpos_q;
  assign bus.ypos      = ypos_q;
  assign bus.frame_upd = frame_upd_q;
  assign bus.w_ack     = w_ack_q;
  assign bus.w_busy    = w_busy_q;

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// Directed bench for mouse_pos_ctrl: hand-computed commit values per frame.
module tb_mouse_pos_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mouse_pos_ctrl_if u_if ();

  mouse_pos_ctrl #(.X_MAX(799), .Y_MAX(599), .X_INIT(400), .Y_INIT(300)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mouse(input logic [11:0] x, input logic [11:0] y);
    u_if.m_valid = 1'b1; u_if.m_xpos = x; u_if.m_ypos = y;
    step();
    u_if.m_valid = 1'b0;
  endtask

  task automatic warp(input logic [11:0] x, input logic [11:0] y);
    u_if.w_req = 1'b1; u_if.w_xpos = x; u_if.w_ypos = y;
    step();
    u_if.w_req = 1'b0;
  endtask

  // vblnk held high three cycles: commit lands two cycles after the rise, once only.
  task automatic frame(input string tag, input int ex, input int ey,
                       input logic eupd, input logic eack);
    u_if.vblnk = 1'b1;
    step();
    chk({tag, "_upd_early"}, 32'(u_if.frame_upd), 0);
    step();
    chk({tag, "_x"}, 32'(u_if.xpos), 32'(ex));
    chk({tag, "_y"}, 32'(u_if.ypos), 32'(ey));
    chk({tag, "_upd"}, 32'(u_if.frame_upd), 32'(eupd));
    chk({tag, "_ack"}, 32'(u_if.w_ack), 32'(eack));
    step();
    chk({tag, "_upd_once"}, 32'(u_if.frame_upd), 0);
    chk({tag, "_ack_once"}, 32'(u_if.w_ack), 0);
    u_if.vblnk = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    u_if.vblnk = 1'b0; u_if.enable = 1'b1;
    u_if.m_valid = 1'b0; u_if.m_xpos = '0; u_if.m_ypos = '0;
    u_if.w_req = 1'b0; u_if.w_xpos = '0; u_if.w_ypos = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_x", 32'(u_if.xpos), 400);
    chk("rst_y", 32'(u_if.ypos), 300);
    chk("rst_busy", 32'(u_if.w_busy), 0);
    chk("rst_ack", 32'(u_if.w_ack), 0);
    chk("rst_upd", 32'(u_if.frame_upd), 0);
    step();

    mouse(12'd100, 12'd200);
    frame("basic", 100, 200, 1'b1, 1'b0);

    mouse(12'd1000, 12'd4000);
    frame("clamp", 799, 599, 1'b1, 1'b0);

    mouse(12'd10, 12'd10); step();
    mouse(12'd20, 12'd20); step();
    mouse(12'd30, 12'd30); step();
    frame("latest", 30, 30, 1'b1, 1'b0);

    warp(12'd50, 12'd60);
    chk("warp_busy_rise", 32'(u_if.w_busy), 1);
    mouse(12'd70, 12'd80);
    chk("warp_busy_hold", 32'(u_if.w_busy), 1);
    frame("warp", 50, 60, 1'b1, 1'b1);
    chk("warp_busy_fall", 32'(u_if.w_busy), 0);
    frame("warp_mouse_lost", 50, 60, 1'b0, 1'b0);

    // Warp and mouse on the same cycle: warp wins.
    u_if.m_valid = 1'b1; u_if.m_xpos = 12'd13; u_if.m_ypos = 12'd14;
    warp(12'd11, 12'd12);
    u_if.m_valid = 1'b0;
    frame("same_cyc", 11, 12, 1'b1, 1'b1);

    // Capture on the vblank-rise cycle while idle waits for the next frame.
    u_if.vblnk = 1'b1;
    mouse(12'd7, 12'd7);
    step();
    chk("idle_rise_upd", 32'(u_if.frame_upd), 0);
    step();
    chk("idle_rise_x", 32'(u_if.xpos), 11);
    u_if.vblnk = 1'b0;
    step();
    frame("idle_rise_next", 7, 7, 1'b1, 1'b0);

    rst = 1'b1; step(); rst = 1'b0;
    mouse(12'd5, 12'd5);
    u_if.enable = 1'b0;
    frame("disabled", 400, 300, 1'b0, 1'b0);
    u_if.enable = 1'b1;
    frame("reenabled", 5, 5, 1'b1, 1'b0);

    warp(12'd9, 12'd9);
    chk("rst_warp_busy", 32'(u_if.w_busy), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_warp_busy_clr", 32'(u_if.w_busy), 0);
    chk("rst_warp_x", 32'(u_if.xpos), 400);
    frame("rst_warp_dropped", 400, 300, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
